// File: rtl/pfvf_route_pkg.sv
// Shared types and default widths for the PF/VF routing lookup table.
package pfvf_route_pkg;

  localparam int PF_W            = 3;
  localparam int VF_W            = 11;
  localparam int PORT_W          = 3;
  localparam int TAG_W           = 8;
  localparam int CNT_W           = 16;
  localparam int NUM_ENTRIES_DEF = 8;
  localparam int IDX_W           = $clog2(NUM_ENTRIES_DEF);

  typedef struct packed {
    logic              valid;
    logic              va;
    logic [PF_W-1:0]   pf;
    logic [VF_W-1:0]   vf;
    logic [PORT_W-1:0] port;
  } entry_t;

  typedef logic [IDX_W-1:0] idx_t;

  localparam int     ENTRY_W    = $bits(entry_t);
  localparam entry_t ENTRY_NULL = entry_t'({ENTRY_W{1'b0}});

  // PF-only entries (va clear) ignore the VF number entirely.
  function automatic logic entry_match(entry_t e, logic [PF_W-1:0] pf,
                                       logic [VF_W-1:0] vf, logic va);
    return e.valid && (e.va == va) && (e.pf == pf) && (!e.va || (e.vf == vf));
  endfunction

endpackage

// File: rtl/pfvf_route_match.sv
// Combinational priority match of one request against the whole entry table;
// the lowest matching index wins.
module pfvf_route_match
  import pfvf_route_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF
) (
  input  entry_t                           entries [NUM_ENTRIES],
  input  logic [PF_W-1:0]                  pf,
  input  logic [VF_W-1:0]                  vf,
  input  logic                             va,
  output logic                             hit,
  output logic [$clog2(NUM_ENTRIES)-1:0]   idx
);

  localparam int IW = $clog2(NUM_ENTRIES);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = {IW{1'b0}};
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match(entries[i], pf, vf, va)) begin
        hit = 1'b1;
        idx = IW'(i);
      end else begin
        hit = hit;
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/pfvf_route_lut.sv
// PF/VF routing lookup table: two-stage valid/ready lookup pipeline over a
// runtime-programmable entry table with saturating hit/miss statistics.
module pfvf_route_lut
  import pfvf_route_pkg::*;
#(
  parameter int NUM_ENTRIES  = NUM_ENTRIES_DEF,
  parameter int PF_WIDTH     = PF_W,
  parameter int VF_WIDTH     = VF_W,
  parameter int PORT_WIDTH   = PORT_W,
  parameter int TAG_WIDTH    = TAG_W,
  parameter int DEFAULT_PORT = 0,
  parameter int CNT_WIDTH    = CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [PF_WIDTH-1:0]              req_pf,
  input  logic [VF_WIDTH-1:0]              req_vf,
  input  logic                             req_va,
  input  logic [TAG_WIDTH-1:0]             req_tag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_hit,
  output logic [PORT_WIDTH-1:0]            rsp_port,
  output logic [$clog2(NUM_ENTRIES)-1:0]   rsp_idx,
  output logic [TAG_WIDTH-1:0]             rsp_tag,
  input  logic                             wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   wr_idx,
  input  entry_t                           wr_entry,
  input  logic                             clr_all,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   rd_idx,
  output entry_t                           rd_entry,
  output logic [CNT_WIDTH-1:0]             hit_cnt,
  output logic [CNT_WIDTH-1:0]             miss_cnt
);

  localparam int                    IW       = $clog2(NUM_ENTRIES);
  localparam logic [IW:0]           NE_S     = (IW+1)'(NUM_ENTRIES);
  localparam logic [PORT_WIDTH-1:0] DEF_PORT = PORT_WIDTH'(DEFAULT_PORT);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  entry_t                table_r [NUM_ENTRIES];
  logic                  s1_valid_r;
  logic [PF_WIDTH-1:0]   s1_pf_r;
  logic [VF_WIDTH-1:0]   s1_vf_r;
  logic                  s1_va_r;
  logic [TAG_WIDTH-1:0]  s1_tag_r;
  logic                  s1_en_s;
  logic                  s2_en_s;
  logic                  match_hit_s;
  logic [IW-1:0]         match_idx_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  assign s2_en_s   = !rsp_valid || rsp_ready;
  assign s1_en_s   = !s1_valid_r || s2_en_s;
  assign req_ready = s1_en_s;
  assign wr_ok_s   = wr_en && ({1'b0, wr_idx} < NE_S);
  assign rd_ok_s   = {1'b0, rd_idx} < NE_S;

  // Compare sees the table as registered, so a write lands for the next compare.
  pfvf_route_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_match (
    .entries (table_r),
    .pf      (s1_pf_r),
    .vf      (s1_vf_r),
    .va      (s1_va_r),
    .hit     (match_hit_s),
    .idx     (match_idx_s)
  );

  // Entry table storage; clr_all overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_r[i] <= ENTRY_NULL;
      end
    end else if (wr_ok_s) begin
      table_r[wr_idx] <= wr_entry;
    end
  end

  // Stage s1: request register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_pf_r    <= {PF_WIDTH{1'b0}};
      s1_vf_r    <= {VF_WIDTH{1'b0}};
      s1_va_r    <= 1'b0;
      s1_tag_r   <= {TAG_WIDTH{1'b0}};
    end else if (s1_en_s) begin
      s1_valid_r <= req_valid;
      s1_pf_r    <= req_pf;
      s1_vf_r    <= req_vf;
      s1_va_r    <= req_va;
      s1_tag_r   <= req_tag;
    end
  end

  // Stage s2: frozen compare result driving the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_port  <= {PORT_WIDTH{1'b0}};
      rsp_idx   <= {IW{1'b0}};
      rsp_tag   <= {TAG_WIDTH{1'b0}};
    end else if (s2_en_s) begin
      rsp_valid <= s1_valid_r;
      if (s1_valid_r) begin
        rsp_hit  <= match_hit_s;
        rsp_port <= match_hit_s ? table_r[match_idx_s].port : DEF_PORT;
        rsp_idx  <= match_hit_s ? match_idx_s : {IW{1'b0}};
        rsp_tag  <= s1_tag_r;
      end
    end
  end

  // Registered readback; out-of-range indices read as an empty entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_entry <= ENTRY_NULL;
    end else begin
      rd_entry <= rd_ok_s ? table_r[rd_idx] : ENTRY_NULL;
    end
  end

  // Saturating statistics, counted on each delivered response.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      hit_cnt  <= {CNT_WIDTH{1'b0}};
      miss_cnt <= {CNT_WIDTH{1'b0}};
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_hit) begin
        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
      end else begin
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pfvf_route_lut.sv
// Directed and randomized checks of pfvf_route_lut against a table-lookup
// reference model with a queue of expected responses.
module tb_pfvf_route_lut;
  import pfvf_route_pkg::*;

  localparam int NE = 6;
  localparam int CW = 4;
  localparam int IW = 3;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_va, rsp_valid, rsp_ready, rsp_hit;
  logic [2:0]    req_pf, rsp_port;
  logic [10:0]   req_vf;
  logic [7:0]    req_tag, rsp_tag;
  logic [IW-1:0] rsp_idx, wr_idx, rd_idx;
  logic          wr_en, clr_all;
  entry_t        wr_entry, rd_entry;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  pfvf_route_lut #(.NUM_ENTRIES(NE), .CNT_WIDTH(CW), .DEFAULT_PORT(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pf(req_pf), .req_vf(req_vf), .req_va(req_va), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_port(rsp_port), .rsp_idx(rsp_idx), .rsp_tag(rsp_tag),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_entry(wr_entry), .clr_all(clr_all),
    .rd_idx(rd_idx), .rd_entry(rd_entry), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic          hit;
    logic [2:0]    port;
    logic [IW-1:0] idx;
    logic [7:0]    tag;
    int            cyc;
  } exp_t;

  exp_t   exp_q[$];
  entry_t m_tab [NE];
  int     m_hit, m_miss, cyc, n_cmp, n_fail;
  bit     last_acc, chk_lat;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk_entry(logic v, logic va, logic [2:0] pf, logic [10:0] vf, logic [2:0] port);
    entry_t e;
    e.valid = v; e.va = va; e.pf = pf; e.vf = vf; e.port = port;
    return e;
  endfunction

  // Reference lookup: first (lowest) entry whose rule holds, else default port 0.
  function automatic exp_t model_lookup(logic [2:0] pf, logic [10:0] vf, logic va, logic [7:0] tag);
    exp_t r;
    r.hit = 1'b0; r.port = 3'd0; r.idx = '0; r.tag = tag; r.cyc = cyc;
    for (int i = 0; i < NE; i++) begin
      if (!r.hit && m_tab[i].valid && m_tab[i].va == va && m_tab[i].pf == pf &&
          (va == 1'b0 || m_tab[i].vf == vf)) begin
        r.hit = 1'b1; r.port = m_tab[i].port; r.idx = i[IW-1:0];
      end
    end
    return r;
  endfunction

  task automatic chk_cnt();
    chk("hit_cnt", 32'(hit_cnt), m_hit);
    chk("miss_cnt", 32'(miss_cnt), m_miss);
  endtask

  // One clock: score handshakes, advance the model, then step past the edge.
  task automatic tick();
    exp_t e;
    bit acc, dlv;
    #1;
    acc = req_valid && req_ready;
    dlv = rsp_valid && rsp_ready;
    last_acc = acc;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NE; i++) m_tab[i] = '0;
      m_hit = 0; m_miss = 0;
    end else begin
      if (dlv) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
          chk("rsp_port", 32'(rsp_port), 32'(e.port));
          chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          if (chk_lat) chk("latency", cyc - e.cyc, 32'd2);
          if (e.hit) m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
          else       m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
        end
      end
      if (clr_all) begin
        for (int i = 0; i < NE; i++) m_tab[i] = '0;
        m_hit = 0; m_miss = 0;
      end else if (wr_en && int'(wr_idx) < NE) begin
        m_tab[wr_idx] = wr_entry;
      end
      if (acc) exp_q.push_back(model_lookup(req_pf, req_vf, req_va, req_tag));
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wr(int idx, entry_t e);
    wr_en = 1'b1; wr_idx = idx[IW-1:0]; wr_entry = e;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send(logic [2:0] pf, logic [10:0] vf, logic va, logic [7:0] tag);
    int n = 0;
    req_valid = 1'b1; req_pf = pf; req_vf = vf; req_va = va; req_tag = tag;
    do begin tick(); n++; end while (!last_acc && n < 20);
    req_valid = 1'b0;
    chk("send_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic rd_chk(int idx, entry_t exp);
    rd_idx = idx[IW-1:0];
    tick();
    chk("rd_entry", 32'(rd_entry), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s_tag;
    logic [2:0] s_port;
    logic       s_hit;
    int         n;
    rst = 1'b1; req_valid = 1'b0; req_pf = '0; req_vf = '0; req_va = 1'b0; req_tag = '0;
    rsp_ready = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_entry = '0; clr_all = 1'b0; rd_idx = '0;
    n_cmp = 0; n_fail = 0; cyc = 0; chk_lat = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_port", 32'(rsp_port), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rd_entry", 32'(rd_entry), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk_cnt();
    rst = 1'b0;

    // Program the four reference entries, read one back, and an out-of-range index
    wr(0, mk_entry(1'b1, 1'b0, 3'd1, 11'd0, 3'd1));
    wr(1, mk_entry(1'b1, 1'b1, 3'd0, 11'd0, 3'd2));
    wr(2, mk_entry(1'b1, 1'b1, 3'd0, 11'd1, 3'd3));
    wr(3, mk_entry(1'b1, 1'b1, 3'd0, 11'd2, 3'd4));
    rd_chk(3, m_tab[3]);
    rd_chk(7, '0);

    // Back-to-back hits, each exactly two cycles after acceptance
    chk_lat = 1'b1;
    send(3'd1, 11'($urandom), 1'b0, 8'h10);
    send(3'd0, 11'd0, 1'b1, 8'h11);
    send(3'd0, 11'd1, 1'b1, 8'h12);
    send(3'd0, 11'd2, 1'b1, 8'h13);
    drain();
    chk_lat = 1'b0;
    chk("hits_after_4", 32'(hit_cnt), 32'd4);

    // Miss goes to the default port
    send(3'd0, 11'd5, 1'b1, 8'h20);
    drain();
    chk("miss_after_1", 32'(miss_cnt), 32'd1);
    chk_cnt();

    // Out-of-range write is ignored
    wr(6, mk_entry(1'b1, 1'b0, 3'd3, 11'd0, 3'd7));
    send(3'd3, 11'd0, 1'b0, 8'h21);
    drain();
    rd_chk(6, '0);

    // Two PF-only entries match; the lower index wins
    wr(2, mk_entry(1'b1, 1'b0, 3'd2, 11'h3ff, 3'd5));
    wr(5, mk_entry(1'b1, 1'b0, 3'd2, 11'd0, 3'd7));
    send(3'd2, 11'($urandom), 1'b0, 8'h30);
    drain();

    // Back-pressure: two accepted, third held, response frozen
    rsp_ready = 1'b0;
    send(3'd1, 11'd9, 1'b0, 8'h40);
    send(3'd0, 11'd0, 1'b1, 8'h41);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_head_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
    s_tag = rsp_tag; s_port = rsp_port; s_hit = rsp_hit;
    req_valid = 1'b1; req_pf = 3'd0; req_vf = 11'd2; req_va = 1'b1; req_tag = 8'h42;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_no_accept", 32'(last_acc), 32'd0);
      chk("stall_tag_hold", 32'(rsp_tag), 32'(s_tag));
      chk("stall_port_hold", 32'(rsp_port), 32'(s_port));
      chk("stall_hit_hold", 32'(rsp_hit), 32'(s_hit));
    end
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 10);
    chk("stall_third_accept", 32'(last_acc), 32'd1);
    drain();
    chk_cnt();

    // Write racing an s1->s2 advance: in-flight request keeps the old port
    send(3'd0, 11'd0, 1'b1, 8'hA1);
    wr_en = 1'b1; wr_idx = 3'd1; wr_entry = mk_entry(1'b1, 1'b1, 3'd0, 11'd0, 3'd6);
    req_valid = 1'b1; req_pf = 3'd0; req_vf = 11'd0; req_va = 1'b1; req_tag = 8'hA2;
    tick();
    chk("race_accept", 32'(last_acc), 32'd1);
    wr_en = 1'b0; req_valid = 1'b0;
    drain();

    // clr_all beats a simultaneous write
    wr_en = 1'b1; wr_idx = 3'd4; wr_entry = mk_entry(1'b1, 1'b0, 3'd1, 11'd0, 3'd3); clr_all = 1'b1;
    tick();
    wr_en = 1'b0; clr_all = 1'b0;
    chk("clr_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("clr_miss_cnt", 32'(miss_cnt), 32'd0);
    rd_chk(4, '0);
    rd_chk(1, '0);
    send(3'd1, 11'd0, 1'b0, 8'hB0);
    drain();

    // Miss counter saturation
    for (int k = 0; k < 20; k++) send(3'(k), 11'(k), 1'b0, 8'(k));
    drain();
    chk("miss_saturated", 32'(miss_cnt), 32'd15);
    chk_cnt();

    // Randomized traffic against a random table
    wr_en = 1'b1; clr_all = 1'b1; tick(); clr_all = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < NE; k++)
      wr(k, mk_entry(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom_range(0, 3)),
                     11'($urandom_range(0, 3)), 3'($urandom)));
    for (int k = 0; k < 300; k++) begin
      req_valid = 1'($urandom); rsp_ready = 1'($urandom_range(0, 3) != 0);
      req_pf = 3'($urandom_range(0, 3)); req_vf = 11'($urandom_range(0, 3));
      req_va = 1'($urandom); req_tag = 8'($urandom);
      tick();
    end
    drain();
    chk_cnt();

    // Reset while a response is stalled
    wr(0, mk_entry(1'b1, 1'b0, 3'd1, 11'd0, 3'd1));
    rsp_ready = 1'b0;
    send(3'd1, 11'd0, 1'b0, 8'hC0);
    send(3'd1, 11'd0, 1'b0, 8'hC1);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    rd_chk(0, '0);
    rsp_ready = 1'b1;
    send(3'd1, 11'd0, 1'b0, 8'hC2);
    drain();
    chk("post_rst_miss", 32'(miss_cnt), 32'd1);
    chk_cnt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
